// File: rtl/wasca_switches_pkg.sv
// Shared constants for the wasca extra-switches input port: register map,
// edge capture encodings and the debounce counter width.
package wasca_switches_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

    localparam logic [1:0] EDGE_RISE = 2'd0;
    localparam logic [1:0] EDGE_FALL = 2'd1;
    localparam logic [1:0] EDGE_ANY  = 2'd2;

    localparam int DEB_CNT_W = 16;

endpackage

// File: rtl/wasca_debounce_bit.sv
// One switch line: two-flop synchroniser, stable-count debouncer and a
// single-cycle edge pulse in the direction selected by EDGE_TYPE.
module wasca_debounce_bit
    import wasca_switches_pkg::*;
#(
    parameter logic [DEB_CNT_W-1:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [1:0]           EDGE_TYPE       = EDGE_ANY,
    parameter logic                 RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_line,
    output logic o_deb,
    output logic o_edge
);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_deb;
    logic                 r_deb_d;
    logic [DEB_CNT_W-1:0] r_cnt;
    logic                 w_rise;
    logic                 w_fall;

    // NOTE: non-blocking assignments let the synchroniser chain shift one
    // stage per clock; blocking would collapse it into a single flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= RESET_LEVEL;
            r_sync2 <= RESET_LEVEL;
            r_deb   <= RESET_LEVEL;
            r_deb_d <= RESET_LEVEL;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_line;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            if (r_sync2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == DEBOUNCE_CYCLES - DEB_CNT_W'(1)) begin
                r_deb <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DEB_CNT_W'(1);
            end
        end
    end

    // r_deb_d tracks r_deb through reset, so no pulse fires as reset deasserts.
    assign w_rise = r_deb & ~r_deb_d;
    assign w_fall = ~r_deb & r_deb_d;

    // NOTE: assigning a default first keeps this block free of inferred latches.
    always_comb begin
        o_edge = w_rise | w_fall;
        if (EDGE_TYPE == EDGE_RISE) o_edge = w_rise;
        if (EDGE_TYPE == EDGE_FALL) o_edge = w_fall;
    end

    assign o_deb = r_deb;

endmodule

// File: rtl/wasca_extra_switches.sv
// Avalon-MM switch/button input port: debounced levels, sticky W1C edge
// capture, per-line interrupt mask and a level irq toward the bridge.
module wasca_extra_switches
    import wasca_switches_pkg::*;
#(
    parameter int                   WIDTH           = 5,
    parameter logic [DEB_CNT_W-1:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [1:0]           EDGE_TYPE       = EDGE_ANY,
    parameter logic                 RESET_LEVEL     = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] w_deb;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_wr_bits;
    logic [WIDTH-1:0] w_clr_bits;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_cap;
    logic [31:0]      w_rd_next;
    logic             w_wr_en;
    logic             w_unused_wdata;

    for (genvar g = 0; g < WIDTH; g++) begin : g_line
        wasca_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .EDGE_TYPE       (EDGE_TYPE),
            .RESET_LEVEL     (RESET_LEVEL)
        ) u_deb (
            .clk    (clk),
            .reset  (reset),
            .i_line (in_port[g]),
            .o_deb  (w_deb[g]),
            .o_edge (w_edge[g])
        );
    end

    assign w_wr_en        = chipselect & ~write_n;
    assign w_wr_bits      = writedata[WIDTH-1:0];
    assign w_clr_bits     = (w_wr_en && address == ADDR_EDGE_CAP) ? w_wr_bits : '0;
    assign w_unused_wdata = ^writedata;

    always_comb begin
        w_rd_next = '0;
        case (address)
            ADDR_DATA:     w_rd_next[WIDTH-1:0] = w_deb;
            ADDR_IRQ_MASK: w_rd_next[WIDTH-1:0] = r_irq_mask;
            ADDR_EDGE_CAP: w_rd_next[WIDTH-1:0] = r_edge_cap;
            default:       w_rd_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_mask <= '0;
            r_edge_cap <= '0;
            readdata   <= '0;
        end else begin
            if (w_wr_en && address == ADDR_IRQ_MASK) r_irq_mask <= w_wr_bits;
            // A new edge overrides a same-cycle clear of that bit.
            r_edge_cap <= (r_edge_cap & ~w_clr_bits) | w_edge;
            readdata   <= w_rd_next;
        end
    end

    assign irq = |(r_edge_cap & r_irq_mask);

endmodule
